// File: rtl/demux_dist_pkg.sv
// Shared constants for the demux stream distributor and its helpers.
//   NUM_CH / SEL_W : channel count and select width of the downstream 1:4 demux
//   MODE_*         : meaning of the mode input
//   state_t        : output register occupancy
package demux_dist_pkg;
  localparam int NUM_CH = 4;
  localparam int SEL_W  = 2;

  localparam logic MODE_RR   = 1'b0;
  localparam logic MODE_ADDR = 1'b1;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;
endpackage

// File: rtl/rr_pick_4.sv
// Rotating-priority picker over a 4-bit mask.
//   mask  : candidate channels
//   start : highest-priority index; search runs start, start+1, ... mod 4
//   pick  : first candidate found (0 when none)
//   any   : at least one candidate present
module rr_pick_4
  import demux_dist_pkg::*;
(
  input  logic [NUM_CH-1:0] mask,
  input  logic [SEL_W-1:0]  start,
  output logic [SEL_W-1:0]  pick,
  output logic              any
);
  logic [SEL_W-1:0] idx;

  always_comb begin
    pick = '0;
    any  = 1'b0;
    idx  = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      // 2-bit add wraps 3->0 for free.
      idx = start + SEL_W'(i);
      if (!any && mask[idx]) begin
        pick = idx;
        any  = 1'b1;
      end
    end
  end
endmodule

// File: rtl/demux_stream_distributor.sv
// One-entry steering stage in front of a 1:4 demux.
//   clk, rst           : clock, synchronous active-high reset
//   mode               : 0 round-robin, 1 addressed (sampled on acceptance)
//   chan_en            : per-channel enable
//   in_valid/in_ready  : input handshake; in_data, in_dest payload/address
//   out_valid          : one-hot valid on channel sel while a beat is held
//   out_ready          : per-channel consumer ready (only out_ready[sel] used)
//   out_data, sel      : registered payload and demux select
//   drop_cnt           : saturating count of beats addressed to disabled channels
module demux_stream_distributor
  import demux_dist_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mode,
  input  logic [NUM_CH-1:0] chan_en,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [SEL_W-1:0]  in_dest,
  output logic [NUM_CH-1:0] out_valid,
  input  logic [NUM_CH-1:0] out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [SEL_W-1:0]  sel,
  output logic [CNT_W-1:0]  drop_cnt
);
  state_t            state_q, state_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic [SEL_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]  drop_q, drop_d;

  logic             all_off, drain, accept;
  logic [SEL_W-1:0] rr_pick;
  logic             rr_any;

  rr_pick_4 u_pick (
    .mask  (chan_en),
    .start (rr_ptr_q),
    .pick  (rr_pick),
    .any   (rr_any)
  );

  assign all_off = (chan_en == '0);
  assign drain   = (state_q == ST_FULL) && out_ready[sel_q];
  // Gated by rst so nothing appears accepted while reset is held.
  assign in_ready = !rst && !all_off && ((state_q == ST_EMPTY) || out_ready[sel_q]);
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_d  = state_q;
    data_d   = data_q;
    sel_d    = sel_q;
    rr_ptr_d = rr_ptr_q;
    drop_d   = drop_q;

    if (drain) state_d = ST_EMPTY;

    if (accept) begin
      if (mode == MODE_ADDR) begin
        if (chan_en[in_dest]) begin
          data_d  = in_data;
          sel_d   = in_dest;
          state_d = ST_FULL;
        end else if (drop_q != '1) begin
          // Consumed but not loaded; state follows the drain alone.
          drop_d = drop_q + CNT_W'(1);
        end
      end else if (rr_any) begin
        // rr_any is always set here since all_off blocks acceptance.
        data_d   = in_data;
        sel_d    = rr_pick;
        rr_ptr_d = rr_pick + SEL_W'(1);
        state_d  = ST_FULL;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_EMPTY;
      data_q   <= '0;
      sel_q    <= '0;
      rr_ptr_q <= '0;
      drop_q   <= '0;
    end else begin
      state_q  <= state_d;
      data_q   <= data_d;
      sel_q    <= sel_d;
      rr_ptr_q <= rr_ptr_d;
      drop_q   <= drop_d;
    end
  end

  assign out_valid = (state_q == ST_FULL) ? (NUM_CH'(1) << sel_q) : '0;
  assign out_data  = data_q;
  assign sel       = sel_q;
  assign drop_cnt  = drop_q;
endmodule

// File: tb/tb_demux_stream_distributor.sv
module tb_demux_stream_distributor;
  logic       clk = 1'b0;
  logic       rst;
  logic       mode;
  logic [3:0] chan_en;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic [1:0] in_dest;
  logic [3:0] out_valid;
  logic [3:0] out_ready;
  logic [7:0] out_data;
  logic [1:0] sel;
  logic [7:0] drop_cnt;

  int n_vec = 0;
  int n_err = 0;

  demux_stream_distributor #(.DATA_W(8), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .mode(mode), .chan_en(chan_en),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_dest(in_dest),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .sel(sel), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a held beat (or nothing), a round-robin pointer and a drop count.
  bit m_full = 0;
  int m_data = 0, m_sel = 0, m_ptr = 0, m_drop = 0;

  always @(posedge clk) begin
    bit rdy, acc;
    if (rst) begin
      m_full = 0; m_data = 0; m_sel = 0; m_ptr = 0; m_drop = 0;
    end else begin
      rdy = (chan_en != 0) && (!m_full || out_ready[m_sel]);
      acc = in_valid && rdy;
      if (m_full && out_ready[m_sel]) m_full = 0;
      if (acc) begin
        if (mode) begin
          if (chan_en[in_dest]) begin
            m_full = 1; m_data = in_data; m_sel = in_dest;
          end else if (m_drop < 255) m_drop++;
        end else begin
          for (int i = 0; i < 4; i++) begin
            int c;
            c = (m_ptr + i) % 4;
            if (chan_en[c]) begin
              m_full = 1; m_data = in_data; m_sel = c; m_ptr = (c + 1) % 4;
              break;
            end
          end
        end
      end
    end
  end

  // Cycle-by-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    bit exp_rdy;
    exp_rdy = !rst && (chan_en != 0) && (!m_full || out_ready[m_sel]);
    chk("m_in_ready", in_ready, exp_rdy);
    chk("m_out_valid", out_valid, m_full ? (32'd1 << m_sel) : 0);
    chk("m_out_data", out_data, m_data);
    chk("m_sel", sel, m_sel);
    chk("m_drop_cnt", drop_cnt, m_drop);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1; mode = 0; chan_en = 4'hF; in_valid = 1; in_data = 8'hAA;
    in_dest = 0; out_ready = 4'hF;

    // Reset held two cycles with in_valid high.
    tick(); chk("rst_in_ready", in_ready, 0);
    tick();
    chk("rst_out_valid", out_valid, 4'b0000);
    chk("rst_sel", sel, 0);
    chk("rst_drop", drop_cnt, 0);
    chk("rst_in_ready2", in_ready, 0);

    // Round-robin streaming, one beat per cycle.
    rst = 0;
    for (int i = 0; i < 5; i++) begin
      in_data = 8'hA0 + 8'(i);
      tick();
      chk("rr_sel", sel, i % 4);
      chk("rr_valid", out_valid, 4'b0001 << (i % 4));
      chk("rr_data", out_data, 8'hA0 + i);
    end
    in_valid = 0;
    tick();
    chk("rr_drained", out_valid, 4'b0000);
    chk("rr_data_kept", out_data, 8'hA4);

    // Skip/wrap over disabled channels (pointer now 1): picks 1,3,1.
    chan_en = 4'b1010; in_valid = 1;
    in_data = 8'hB0; tick(); chk("skip_sel0", sel, 1);
    in_data = 8'hB1; tick(); chk("skip_sel1", sel, 3);
    in_data = 8'hB2; tick(); chk("skip_sel2", sel, 1);
    chk("skip_valid2", out_valid, 4'b0010);
    chan_en = 4'b0000; #1;
    chk("alloff_in_ready", in_ready, 0);
    tick();
    chk("alloff_drop", drop_cnt, 0);
    chk("alloff_valid", out_valid, 4'b0000);

    // Addressed load, then a drop to a disabled channel.
    mode = 1; chan_en = 4'b0111; in_dest = 2; in_data = 8'h55;
    tick();
    chk("addr_sel", sel, 2);
    chk("addr_valid", out_valid, 4'b0100);
    chk("addr_data", out_data, 8'h55);
    in_dest = 3; in_data = 8'h66; #1;
    chk("drop_in_ready", in_ready, 1);
    tick();
    chk("drop_cnt1", drop_cnt, 1);
    chk("drop_valid", out_valid, 4'b0000);
    chk("drop_no_load", out_data, 8'h55);
    for (int i = 0; i < 260; i++) tick();
    chk("drop_sat", drop_cnt, 8'd255);

    // Backpressure on the held channel.
    in_dest = 1; in_data = 8'h11;
    tick();
    chk("bp_load", out_valid, 4'b0010);
    out_ready = 4'b1101; in_dest = 2; in_data = 8'h22;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_in_ready", in_ready, 0);
      chk("bp_valid", out_valid, 4'b0010);
      chk("bp_data", out_data, 8'h11);
    end
    out_ready = 4'hF;
    tick();
    chk("bp_next_sel", sel, 2);
    chk("bp_next_data", out_data, 8'h22);
    in_valid = 0;
    tick();

    // Reset while holding a beat on channel 2.
    mode = 0; chan_en = 4'b0100; in_valid = 1; in_data = 8'h77;
    tick();
    chk("mid_sel", sel, 2);
    out_ready = 4'h0; in_valid = 0;
    tick();
    chk("mid_hold", out_valid, 4'b0100);
    rst = 1;
    tick();
    chk("mid_rst_valid", out_valid, 4'b0000);
    chk("mid_rst_sel", sel, 0);
    rst = 0; chan_en = 4'hF; out_ready = 4'hF; in_valid = 1; in_data = 8'h88;
    tick();
    chk("mid_ptr0", sel, 0);
    chk("mid_data", out_data, 8'h88);
    in_valid = 0;
    tick(); tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/demux_stream_distributor.md
Name: demux_stream_distributor

Overview:
- Sequential steering stage directly upstream of the 1:4 demux (I, S[1:0] -> Y[3:0]).
- Accepts a valid/ready input stream and holds each beat in a one-entry output register.
- Chooses a destination channel by round-robin or by explicit address, and drives the demux select.
- Supplies the per-channel valid, honours per-channel backpressure, and counts beats dropped to disabled channels.

Parameters:
- DATA_W, 8, width of payload beat.
- CNT_W, 8, width of saturating drop counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous active-high reset.
- mode  input  1  0 = round-robin, 1 = addressed; sampled only at input acceptance.
- chan_en  input  4  per-channel enable mask.
- in_valid  input  1  input beat valid.
- in_ready  output  1  input beat accepted when in_valid & in_ready.
- in_data  input  DATA_W  input payload.
- in_dest  input  2  destination channel, used in addressed mode only.
- out_valid  output  4  one-hot valid for channel sel; all zero when empty.
- out_ready  input  4  per-channel ready from consumers.
- out_data  output  DATA_W  registered payload; feeds demux I (bit 0 when DATA_W=1).
- sel  output  2  registered channel index; feeds demux S.
- drop_cnt  output  CNT_W  saturating count of dropped beats.

Behaviour:
- Clocking and reset: one clock (clk); reset (rst) is synchronous and active-high.
- Reset values: state=EMPTY, out_valid=0000, out_data=0, sel=00, rr_ptr=00, drop_cnt=0.
- Reset mid-operation discards any held beat with no handshake to the consumer.
- States:
  - EMPTY: nothing held.
  - FULL: beat held; out_valid[sel]=1, all other out_valid bits 0.
- Output handshake (FULL): completes when out_ready[sel]=1. out_ready bits for other channels are ignored.
- in_ready = ~all_off & (state==EMPTY | out_ready[sel]), where all_off = (chan_en==0).
  - Full throughput: a simultaneous drain and accept in FULL keeps state FULL and loads the new beat that same edge.
  - Combinational path out_ready->in_ready is allowed.
- Addressed mode acceptance:
  - chan_en[in_dest]=1: load out_data=in_data, sel=in_dest, go FULL. rr_ptr unchanged.
  - chan_en[in_dest]=0: beat is dropped. in_ready is still asserted per the rule above; the beat is consumed and not loaded. drop_cnt += 1, saturating at all-ones. State follows the drain only (FULL->EMPTY if the held beat drained that cycle).
- Round-robin mode acceptance:
  - Search enabled channels in order rr_ptr, rr_ptr+1, ... modulo 4 (wrap 3->0). First enabled channel = pick.
  - Load sel=pick, then rr_ptr = pick+1 mod 4.
  - all_off forces in_ready=0: no acceptance and no drop.
- Drain without accept: FULL -> EMPTY, out_valid -> 0000. out_data and sel retain last values.
- Held beat is immune to later changes of mode, chan_en or in_dest. Disabling chan_en[sel] while FULL does not cancel the beat; it waits for out_ready[sel].
- Latency: accept at edge N gives out_valid at N+1 (one-cycle register latency). No combinational in->out data path.
- in_data and in_dest are don't-care when in_valid=0.

Decomposition:
- Package demux_dist_pkg:
  - NUM_CH=4, SEL_W=2.
  - MODE_RR=1'b0, MODE_ADDR=1'b1.
  - State encoding ST_EMPTY/ST_FULL.
- Sub-module rr_pick_4:
  - Inputs: 4-bit mask, 2-bit start pointer.
  - Outputs: 2-bit pick, 1-bit any.
  - Combinational rotate-priority search. Reusable by other arbiters in the design.

Test Plan:
- Reset/idle: assert rst 2 cycles with in_valid=1 -> out_valid=0000, sel=00, drop_cnt=0, in_ready=0 throughout reset. First accept occurs only after rst falls.
- Round-robin, streaming: mode=0, chan_en=1111, out_ready=1111, in_valid held 1 with data A0,A1,A2,A3,A4 -> one beat per cycle. sel sequence 0,1,2,3,0; out_valid 0001,0010,0100,1000,0001; out_data matches, one cycle late.
- Round-robin skip/wrap: chan_en=1010, rr_ptr=0, three beats -> sel 1,3,1. Then chan_en=0000 -> in_ready=0, drop_cnt unchanged.
- Addressed + drop: mode=1, chan_en=0111, in_dest=2 data 55 -> sel=2, out_valid=0100. in_dest=3 data 66 -> in_ready=1, no load, drop_cnt=1. Force drop_cnt to 255 then drop again -> stays 255.
- Backpressure: hold out_ready[sel]=0 for 5 cycles with new input pending -> in_ready=0, out_data/sel stable, out_valid constant. Raise out_ready[sel] -> drain and accept same edge, next beat appears the next cycle.
- Reset mid-hold: FULL on channel 2 with out_ready=0, pulse rst one cycle -> out_valid=0000, sel=00, rr_ptr=0 next cycle. Held beat never handshaken.
